// File: rtl/fft_bfly_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_bfly_addr_gen
//   Butterfly address generator for an iterative radix-2 DIT FFT.
//   For every stage it issues N/2 (A, B, twiddle) triples through a
//   valid/ready handshake. Between stages it pulses o_STAGE_EN for one cycle
//   so the external one-hot stage ring register advances. After the last
//   stage it pulses o_DONE.
//
//   Optional build macro: FFT_ADDR_GEN_CHECK_EN
//     Adds o_ERR, a sticky flag raised in RUN when i_STAGE_OH disagrees with
//     the internal stage counter or is not one-hot. In that build the
//     addresses follow the internal stage counter.
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   i_START     frame start request, sampled in IDLE only
//   i_STAGE_OH  one-hot current stage from the ring register
//   o_STAGE_EN  one-cycle pulse that advances the ring register
//   o_ADDR_A    butterfly upper-input address
//   o_ADDR_B    butterfly lower-input address
//   o_TW_IDX    twiddle ROM index
//   o_VALID     address triple valid
//   i_READY     datapath accepts the triple when o_VALID && i_READY
//   o_BUSY      high in every state except IDLE
//   o_DONE      one-cycle pulse after the last stage
//   o_ERR       (FFT_ADDR_GEN_CHECK_EN only) sticky stage-vector error
// -----------------------------------------------------------------------------
module fft_bfly_addr_gen #(
   parameter int LOG2N  = 10,
   parameter int ADDR_W = LOG2N
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              i_START,
   input  logic [LOG2N-1:0]  i_STAGE_OH,
   output logic              o_STAGE_EN,
   output logic [ADDR_W-1:0] o_ADDR_A,
   output logic [ADDR_W-1:0] o_ADDR_B,
   output logic [LOG2N-2:0]  o_TW_IDX,
   output logic              o_VALID,
   input  logic              i_READY,
   output logic              o_BUSY,
   output logic              o_DONE
`ifdef FFT_ADDR_GEN_CHECK_EN
   ,
   output logic              o_ERR
`endif
);

   localparam int K_W = LOG2N - 1;
   localparam int S_W = $clog2(LOG2N);
   localparam logic [K_W-1:0] K_LAST     = '1;
   localparam logic [S_W-1:0] STAGE_LAST = S_W'(LOG2N - 1);

   typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_t;

   state_t           state_reg, state_next;
   logic [K_W-1:0]   k_reg, k_next;
   logic [S_W-1:0]   stage_reg, stage_next;
   logic [LOG2N-1:0] a_reg, a_next;
   logic [LOG2N-1:0] b_reg, b_next;
   logic [K_W-1:0]   tw_reg, tw_next;

   // Stage index used for address generation
   logic [S_W-1:0]   s_cur;

`ifdef FFT_ADDR_GEN_CHECK_EN
   logic err_reg;
   assign s_cur = stage_reg;

   always_ff @(posedge CLK) begin
      if (RST)
         err_reg <= 1'b0;
      else if (state_reg == RUN && i_STAGE_OH != (LOG2N'(1) << stage_reg))
         err_reg <= 1'b1;
   end
   assign o_ERR = err_reg;
`else
   // One-hot to binary: OR together the index of every set bit
   logic [S_W-1:0] idx_term [LOG2N];
   logic [S_W-1:0] s_oh;

   generate
      for (genvar gi = 0; gi < LOG2N; gi++) begin : g_dec
         assign idx_term[gi] = i_STAGE_OH[gi] ? S_W'(gi) : '0;
      end
   endgenerate

   always_comb begin
      s_oh = '0;
      for (int i = 0; i < LOG2N; i++)
         s_oh = s_oh | idx_term[i];
   end
   assign s_cur = s_oh;
`endif

   // Next triple to load. Leaving STEP the ring register has not yet moved,
   // so the new stage is taken as the current one plus one.
   logic [K_W-1:0]   k_calc;
   logic [S_W-1:0]   s_calc;
   logic [LOG2N-1:0] span, mask, kx;
   logic [LOG2N-1:0] a_calc, b_calc;
   logic [K_W-1:0]   tw_calc;

   always_comb begin
      k_calc  = (state_reg == RUN) ? k_reg + 1'b1 : '0;
      s_calc  = (state_reg == STEP) ? s_cur + 1'b1 : s_cur;
      span    = LOG2N'(1) << s_calc;
      mask    = span - 1'b1;
      kx      = LOG2N'(k_calc);
      // Insert a zero at bit s of k for A; B sets that bit
      a_calc  = ((kx & ~mask) << 1) | (kx & mask);
      b_calc  = a_calc | span;
      tw_calc = K_W'((kx & mask) << (K_W - int'(s_calc)));
   end

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      stage_next = stage_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      tw_next    = tw_reg;
      case (state_reg)
         IDLE: begin
            if (i_START) begin
               state_next = RUN;
               k_next     = '0;
               stage_next = '0;
               a_next     = a_calc;
               b_next     = b_calc;
               tw_next    = tw_calc;
            end
         end
         RUN: begin
            if (i_READY) begin
               if (k_reg == K_LAST) begin
                  state_next = STEP;
                  k_next     = '0;
                  a_next     = '0;
                  b_next     = '0;
                  tw_next    = '0;
               end else begin
                  k_next  = k_calc;
                  a_next  = a_calc;
                  b_next  = b_calc;
                  tw_next = tw_calc;
               end
            end
         end
         STEP: begin
            if (stage_reg == STAGE_LAST) begin
               state_next = DONE;
               stage_next = '0;
            end else begin
               state_next = RUN;
               stage_next = stage_reg + 1'b1;
               a_next     = a_calc;
               b_next     = b_calc;
               tw_next    = tw_calc;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         stage_reg <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         tw_reg    <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         stage_reg <= stage_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         tw_reg    <= tw_next;
      end
   end

   assign o_VALID    = (state_reg == RUN);
   assign o_STAGE_EN = (state_reg == STEP);
   assign o_DONE     = (state_reg == DONE);
   assign o_BUSY     = (state_reg != IDLE);
   assign o_ADDR_A   = ADDR_W'(a_reg);
   assign o_ADDR_B   = ADDR_W'(b_reg);
   assign o_TW_IDX   = tw_reg;

endmodule
